time_sync_req_queue: RTL and testbench
======================================

// Module: time_sync_req_queue
// PURPOSE
//  Downstream of the sync scheduler. Converts per-interface sync_enable levels into discrete,
//  timestamped sync requests and queues them in one small FIFO per interface.
//  The time sync master frame generator drains each queue over a valid/ready handshake.
//  Each request carries the PTP ToD captured at the trigger edge, the destination ID and a
//  per-interface sequence number.
// PARAMETERS
//  IF_COUNT          2     number of interfaces / independent queues
//  IDENTIFIER_WIDTH  16    destination ID width
//  SEQ_WIDTH         16    per-interface sequence number width
//  FIFO_DEPTH        4     entries per interface queue; power of two, >=2
//  HOLDOFF_CYCLES    125   min clk cycles between accepted requests (only with TIME_SYNC_REQ_HOLDOFF_EN)
// PORTS
//  clk              in   1                      clock
//  rst              in   1                      async reset, active-high
//  ptp_ts_tod       in   96                     PTP ToD {sec[95:48], ns[47:16], fns[15:0]}
//  sync_enable_in   in   IF_COUNT               per-interface trigger level from scheduler
//  sync_dest_id_in  in   IF_COUNT*IDENTIFIER_WIDTH  dest ID per interface, valid with enable
//  m_req_valid      out  IF_COUNT               request available (queue non-empty)
//  m_req_ready      in   IF_COUNT               consumer accepts head entry
//  m_req_dest_id    out  IF_COUNT*IDENTIFIER_WIDTH  head entry dest ID
//  m_req_ts         out  IF_COUNT*96            head entry captured ToD
//  m_req_seq        out  IF_COUNT*SEQ_WIDTH     head entry sequence number
//  drop_count       out  IF_COUNT*16            saturating count of discarded triggers
// BEHAVIOUR
//  - Reset (async, active-high): all queues empty, m_req_valid=0, data outputs=0, seq counters=0,
//    drop_count=0, holdoff counters=0, edge-detect history=all ones. An enable already high when
//    reset deasserts does not trigger.
//  - Trigger, per interface n: sync_enable_in[n]=1 at a clk edge where the previous sample was 0.
//    Only the rising edge counts; a held-high level yields one trigger.
//  - On a trigger at edge k, ts=ptp_ts_tod and dest=sync_dest_id_in[n] are sampled at edge k.
//    If queue n is not full, {ts,dest,seq[n]} is written at edge k and seq[n] increments
//    (wraps modulo 2^SEQ_WIDTH). m_req_valid[n] is high in cycle k+1 (1-cycle latency).
//  - Queue full: the trigger is dropped, seq[n] is unchanged, and drop_count[n]++ saturates at 16'hFFFF.
//  - Full with a pop in the same cycle (valid&ready): the pop frees a slot, so the push is
//    accepted and the level is unchanged.
//  - Output is first-word-fall-through. m_req_* show the head entry whenever valid=1; data
//    outputs are 0 when empty. Pop happens on m_req_valid[n]&m_req_ready[n]. A push into an
//    empty queue is visible the next cycle, never combinationally.
//  - ready while empty: no effect. Push and pop on a non-full queue: level unchanged, order kept.
//  - Interfaces are fully independent; simultaneous triggers on all interfaces are all accepted.
//  - Pointers are log2(FIFO_DEPTH)+1 bits wide. Full = MSBs differ and lower bits equal.
// CONFIGURATION
//  TIME_SYNC_REQ_HOLDOFF_EN defined:
//   - A per-interface counter loads HOLDOFF_CYCLES-1 on each accepted trigger and decrements to 0.
//   - A trigger while the counter is non-zero is discarded and increments drop_count[n].
//   - Triggers dropped because the queue is full do not load the counter.
//  Not defined: no holdoff logic; every rising edge is subject only to the FIFO-full rule.
// TESTING
//  - Reset, then pulse sync_enable_in[0] for 1 cycle with ToD ns=60000, dest 16'h1176 ->
//    next cycle m_req_valid[0]=1, ts ns field=60000, dest=1176, seq=0. m_req_valid[1] stays 0.
//  - Hold enable[0] high for 10 cycles -> exactly one entry queued.
//  - ready=0, 6 triggers on if0 (depth 4) -> 4 entries with seq 0..3, drop_count[0]=2.
//    Raise ready -> 4 pops in order, then valid=0.
//  - Queue full, and a new trigger coincides with a pop -> trigger accepted (seq 4), level stays 4,
//    drop_count unchanged.
//  - Enable high across a reset assert/deassert -> no entry after reset. Entries queued before
//    reset are gone and seq restarts at 0.
//  - HOLDOFF_EN, HOLDOFF_CYCLES=8: triggers 3 cycles apart -> 2nd dropped (drop_count=1).
//    A trigger 8 cycles after the 1st is accepted.

Source files
------------

// File: rtl/time_sync_req_queue.sv
// Turns per-interface sync_enable levels into timestamped requests held in one FWFT queue per interface.
// Optional TIME_SYNC_REQ_HOLDOFF_EN enforces a minimum spacing between accepted requests.
module time_sync_req_lane #(
    parameter int IDW     = 16,
    parameter int SEQW    = 16,
    parameter int DEPTH   = 4,
    parameter int HOLDOFF = 125
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [95:0]     tod,
    input  logic            en,
    input  logic [IDW-1:0]  dest_in,
    output logic            valid,
    input  logic            ready,
    output logic [IDW-1:0]  dest_out,
    output logic [95:0]     ts_out,
    output logic [SEQW-1:0] seq_out,
    output logic [15:0]     drop_count
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (HOLDOFF < 1) begin : g_bad_holdoff
        $error("HOLDOFF_CYCLES must be >= 1");
    end

    logic [95:0]     ts_mem_q   [DEPTH];
    logic [95:0]     ts_mem_d   [DEPTH];
    logic [IDW-1:0]  dest_mem_q [DEPTH];
    logic [IDW-1:0]  dest_mem_d [DEPTH];
    logic [SEQW-1:0] seq_mem_q  [DEPTH];
    logic [SEQW-1:0] seq_mem_d  [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [SEQW-1:0] seq_q, seq_d;
    logic [15:0]     drop_q, drop_d;
    logic            en_prev_q, en_prev_d;
    logic            empty, full, pop, push, trig, hold_busy;

`ifdef TIME_SYNC_REQ_HOLDOFF_EN
    localparam int HW = $clog2(HOLDOFF + 1);
    logic [HW-1:0] hold_q, hold_d;

    assign hold_busy = |hold_q;

    always_comb begin
        hold_d = hold_q;
        if (push)
            hold_d = HW'(HOLDOFF - 1);
        else if (hold_busy)
            hold_d = hold_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_q <= '0;
        else     hold_q <= hold_d;
    end
`else
    assign hold_busy = 1'b0;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign trig  = en && !en_prev_q;
    assign pop   = !empty && ready;
    // A same-cycle pop frees a slot, so a full queue can still take the push.
    assign push  = trig && !hold_busy && (!full || pop);

    assign valid    = !empty;
    assign ts_out   = valid ? ts_mem_q[rd_ptr_q[AW-1:0]]   : '0;
    assign dest_out = valid ? dest_mem_q[rd_ptr_q[AW-1:0]] : '0;
    assign seq_out  = valid ? seq_mem_q[rd_ptr_q[AW-1:0]]  : '0;
    assign drop_count = drop_q;

    always_comb begin
        ts_mem_d   = ts_mem_q;
        dest_mem_d = dest_mem_q;
        seq_mem_d  = seq_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        seq_d      = seq_q;
        drop_d     = drop_q;
        en_prev_d  = en;
        if (push) begin
            ts_mem_d[wr_ptr_q[AW-1:0]]   = tod;
            dest_mem_d[wr_ptr_q[AW-1:0]] = dest_in;
            seq_mem_d[wr_ptr_q[AW-1:0]]  = seq_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
            seq_d    = seq_q + 1'b1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        if (trig && !push && drop_q != 16'hFFFF)
            drop_d = drop_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_q[i]   <= '0;
                dest_mem_q[i] <= '0;
                seq_mem_q[i]  <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            seq_q     <= '0;
            drop_q    <= '0;
            en_prev_q <= 1'b1;  // a level already high out of reset is not an edge
        end else begin
            ts_mem_q   <= ts_mem_d;
            dest_mem_q <= dest_mem_d;
            seq_mem_q  <= seq_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            en_prev_q  <= en_prev_d;
        end
    end
endmodule

module time_sync_req_queue #(
    parameter int IF_COUNT         = 2,
    parameter int IDENTIFIER_WIDTH = 16,
    parameter int SEQ_WIDTH        = 16,
    parameter int FIFO_DEPTH       = 4,
    parameter int HOLDOFF_CYCLES   = 125
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [95:0]                          ptp_ts_tod,
    input  logic [IF_COUNT-1:0]                  sync_enable_in,
    input  logic [IF_COUNT*IDENTIFIER_WIDTH-1:0] sync_dest_id_in,
    output logic [IF_COUNT-1:0]                  m_req_valid,
    input  logic [IF_COUNT-1:0]                  m_req_ready,
    output logic [IF_COUNT*IDENTIFIER_WIDTH-1:0] m_req_dest_id,
    output logic [IF_COUNT*96-1:0]               m_req_ts,
    output logic [IF_COUNT*SEQ_WIDTH-1:0]        m_req_seq,
    output logic [IF_COUNT*16-1:0]               drop_count
);
    for (genvar n = 0; n < IF_COUNT; n++) begin : g_lane
        time_sync_req_lane #(
            .IDW(IDENTIFIER_WIDTH), .SEQW(SEQ_WIDTH), .DEPTH(FIFO_DEPTH), .HOLDOFF(HOLDOFF_CYCLES)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .tod        (ptp_ts_tod),
            .en         (sync_enable_in[n]),
            .dest_in    (sync_dest_id_in[n*IDENTIFIER_WIDTH +: IDENTIFIER_WIDTH]),
            .valid      (m_req_valid[n]),
            .ready      (m_req_ready[n]),
            .dest_out   (m_req_dest_id[n*IDENTIFIER_WIDTH +: IDENTIFIER_WIDTH]),
            .ts_out     (m_req_ts[n*96 +: 96]),
            .seq_out    (m_req_seq[n*SEQ_WIDTH +: SEQ_WIDTH]),
            .drop_count (drop_count[n*16 +: 16])
        );
    end
endmodule

// File: tb/tb_time_sync_req_queue.sv
// Scoreboard bench: stimulus pushes hand-computed requests, a negedge monitor checks every pop.
module tb_time_sync_req_queue;
    localparam int IFC = 2;
`ifdef TIME_SYNC_REQ_HOLDOFF_EN
    localparam int HOLD = 8;
    localparam int GAP  = 8;
`else
    localparam int HOLD = 125;
    localparam int GAP  = 2;
`endif

    typedef struct {
        logic [95:0] ts;
        logic [15:0] dest;
        logic [15:0] seq;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [95:0]   ptp_ts_tod = '0;
    logic [1:0]    sync_enable_in = '0;
    logic [31:0]   sync_dest_id_in = '0;
    logic [1:0]    m_req_valid;
    logic [1:0]    m_req_ready = '0;
    logic [31:0]   m_req_dest_id;
    logic [191:0]  m_req_ts;
    logic [31:0]   m_req_seq;
    logic [31:0]   drop_count;

    exp_t exp_q[IFC][$];
    int checks = 0;
    int failures = 0;

    time_sync_req_queue #(
        .IF_COUNT(IFC), .IDENTIFIER_WIDTH(16), .SEQ_WIDTH(16), .FIFO_DEPTH(4), .HOLDOFF_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .ptp_ts_tod(ptp_ts_tod), .sync_enable_in(sync_enable_in),
        .sync_dest_id_in(sync_dest_id_in), .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_dest_id(m_req_dest_id), .m_req_ts(m_req_ts), .m_req_seq(m_req_seq),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [95:0] mk_tod(input int ns);
        logic [31:0] ns32;
        ns32 = ns;
        return {48'd5, ns32, 16'h0};
    endfunction

    // Any handshake the monitor sees must match the oldest expected request.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int n = 0; n < IFC; n++) begin
                if (m_req_valid[n] && m_req_ready[n]) begin
                    if (exp_q[n].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pop_if%0d actual seq=%0h required=no entry",
                                 n, m_req_seq[n*16 +: 16]);
                    end else begin
                        e = exp_q[n].pop_front();
                        chk($sformatf("pop_ts_if%0d", n),   m_req_ts[n*96 +: 96],      e.ts);
                        chk($sformatf("pop_dest_if%0d", n), m_req_dest_id[n*16 +: 16], e.dest);
                        chk($sformatf("pop_seq_if%0d", n),  m_req_seq[n*16 +: 16],     e.seq);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse(input logic [1:0] m, input logic [15:0] d0, input logic [15:0] d1,
                         input int ns, input logic [1:0] acc, input logic [15:0] s0,
                         input logic [15:0] s1);
        ptp_ts_tod      = mk_tod(ns);
        sync_dest_id_in = {d1, d0};
        sync_enable_in  = m;
        if (acc[0]) exp_q[0].push_back('{mk_tod(ns), d0, s0});
        if (acc[1]) exp_q[1].push_back('{mk_tod(ns), d1, s1});
        tick();
        sync_enable_in = '0;
        idle(GAP - 1);
    endtask

    task automatic drain(input int n);
        bit ok = 1'b0;
        m_req_ready[n] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!m_req_valid[n]) begin
                ok = 1'b1;
                break;
            end
        end
        m_req_ready[n] = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout_if%0d actual=valid stuck required=empty", n);
        end
        chk($sformatf("drain_left_if%0d", n), exp_q[n].size(), 0);
        chk($sformatf("empty_dest_zero_if%0d", n), m_req_dest_id[n*16 +: 16], 0);
    endtask

    initial begin
        // reset state
        idle(3);
        chk("rst_valid", m_req_valid, 0);
        chk("rst_ts", m_req_ts[127:0], 0);
        chk("rst_seq", m_req_seq, 0);
        chk("rst_drop", drop_count, 0);
        rst = 1'b0;
        idle(2);

        // single pulse, 1-cycle latency
        ptp_ts_tod      = mk_tod(60000);
        sync_dest_id_in = {16'h0, 16'h1176};
        sync_enable_in  = 2'b01;
        exp_q[0].push_back('{mk_tod(60000), 16'h1176, 16'd0});
        #1;
        chk("no_comb_valid", m_req_valid[0], 0);
        tick();
        sync_enable_in = '0;
        chk("t1_valid0", m_req_valid[0], 1);
        chk("t1_valid1", m_req_valid[1], 0);
        chk("t1_ns", m_req_ts[47:16], 60000);
        chk("t1_dest", m_req_dest_id[15:0], 16'h1176);
        chk("t1_seq", m_req_seq[15:0], 0);
        drain(0);

        // held-high level gives one entry
        idle(GAP);
        ptp_ts_tod      = mk_tod(100);
        sync_dest_id_in = {16'h0, 16'h0202};
        exp_q[0].push_back('{mk_tod(100), 16'h0202, 16'd1});
        sync_enable_in  = 2'b01;
        idle(10);
        sync_enable_in  = '0;
        idle(1);
        drain(0);

        // enable high across reset, pending entry discarded
        idle(GAP);
        pulse(2'b01, 16'h0BAD, 16'h0, 200, 2'b00, 16'd0, 16'd0);
        chk("pre_rst_valid", m_req_valid[0], 1);
        sync_enable_in = 2'b01;
        tick();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_valid", m_req_valid[0], 0);
        end
        sync_enable_in = '0;
        idle(GAP);

        // fill beyond depth: 4 accepted, 2 dropped
        for (int i = 0; i < 6; i++)
            pulse(2'b01, 16'h2000 + 16'(i), 16'h0, 1000 + i, {1'b0, i < 4}, 16'(i), 16'd0);
        chk("fill_drop", drop_count[15:0], 2);
        chk("fill_valid", m_req_valid[0], 1);

        // full + simultaneous pop: push accepted
        idle(GAP);
        ptp_ts_tod      = mk_tod(5000);
        sync_dest_id_in = {16'h0, 16'h3333};
        exp_q[0].push_back('{mk_tod(5000), 16'h3333, 16'd4});
        sync_enable_in  = 2'b01;
        m_req_ready[0]  = 1'b1;
        tick();
        sync_enable_in  = '0;
        m_req_ready[0]  = 1'b0;
        chk("fullpop_drop", drop_count[15:0], 2);
        tick();
        // level is still 4, so the next trigger is dropped
        pulse(2'b01, 16'h4444, 16'h0, 6000, 2'b00, 16'd0, 16'd0);
        chk("still_full_drop", drop_count[15:0], 3);
        drain(0);

        // simultaneous triggers on both interfaces
        idle(GAP);
        pulse(2'b11, 16'hA0A0, 16'hB1B1, 777, 2'b11, 16'd5, 16'd0);
        chk("both_valid", m_req_valid, 2'b11);
        drain(0);
        drain(1);
        chk("if1_drop", drop_count[31:16], 0);

`ifdef TIME_SYNC_REQ_HOLDOFF_EN
        // holdoff: 3 cycles later dropped, 8 cycles later accepted
        idle(GAP);
        ptp_ts_tod      = mk_tod(9000);
        sync_dest_id_in = {16'h0, 16'h0901};
        exp_q[0].push_back('{mk_tod(9000), 16'h0901, 16'd6});
        sync_enable_in  = 2'b01;
        tick();
        sync_enable_in  = '0;
        idle(2);
        sync_enable_in  = 2'b01;
        tick();
        sync_enable_in  = '0;
        chk("holdoff_drop", drop_count[15:0], 4);
        idle(4);
        ptp_ts_tod      = mk_tod(9008);
        sync_dest_id_in = {16'h0, 16'h0908};
        exp_q[0].push_back('{mk_tod(9008), 16'h0908, 16'd7});
        sync_enable_in  = 2'b01;
        tick();
        sync_enable_in  = '0;
        chk("holdoff_drop_after", drop_count[15:0], 4);
        drain(0);
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
